reflet_dma: RTL and testbench

REFLET_DMA -- requirements
Module: reflet_dma

---
 rtl/reflet_dma.sv | 154 +++++++++++++++
 tb/tb_reflet_dma.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reflet_dma.sv
// reflet_dma: single-channel memory-to-memory copy engine.
//
// The CPU programs SRC, DST and LEN through a small register port, then
// writes CTRL[0]=1. The engine takes the system bus (bus_request), copies
// LEN words one at a time (one READ cycle, one WRITE cycle per word),
// releases the bus and pulses irq for one cycle.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   enable, addr,        register port: 0=SRC 1=DST 2=LEN 3=CTRL
//   write_en, data_in,
//   data_out             read data, 0 when enable=0 (OR-combinable)
//   bus_request          high while the engine owns the bus
//   m_addr, m_write_en,  initiator side, all 0 when bus_request=0
//   m_data_out
//   m_data_in            OR-combined responder read data
//   irq                  one-cycle completion pulse
//   CTRL read value: {0..., done, busy}

module reflet_dma #(
    parameter int wordsize = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [1:0]          addr,
    input  logic                write_en,
    input  logic [wordsize-1:0] data_in,
    output logic [wordsize-1:0] data_out,
    output logic                bus_request,
    output logic [wordsize-1:0] m_addr,
    output logic                m_write_en,
    output logic [wordsize-1:0] m_data_out,
    input  logic [wordsize-1:0] m_data_in,
    output logic                irq
);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        READ,
        WRITE,
        FINISH
    } state_t;

    localparam logic [wordsize-1:0] one = wordsize'(1);

    state_t              state;
    logic [wordsize-1:0] src;
    logic [wordsize-1:0] dst;
    logic [wordsize-1:0] len;
    logic                done;
    logic                busy;
    logic [wordsize-1:0] ctrl_val;

    assign busy = (state != IDLE);

    // Outputs are registered: each transition loads the values the bus
    // must show during the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            src         <= '0;
            dst         <= '0;
            len         <= '0;
            done        <= 1'b0;
            irq         <= 1'b0;
            bus_request <= 1'b0;
            m_addr      <= '0;
            m_write_en  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    irq <= 1'b0;
                    if (enable && write_en) begin
                        case (addr)
                            2'd0: src <= data_in;
                            2'd1: dst <= data_in;
                            2'd2: len <= data_in;
                            default: begin
                                if (data_in[0]) begin
                                    if (len != '0) begin
                                        state       <= GRANT;
                                        bus_request <= 1'b1;
                                        done        <= 1'b0;
                                    end else begin
                                        // empty transfer: complete without touching the bus
                                        state <= FINISH;
                                        done  <= 1'b1;
                                        irq   <= 1'b1;
                                    end
                                end else if (data_in[1]) begin
                                    done <= 1'b0;
                                end
                            end
                        endcase
                    end
                end
                GRANT: begin
                    state  <= READ;
                    m_addr <= src;
                end
                READ: begin
                    state      <= WRITE;
                    m_addr     <= dst;
                    m_write_en <= 1'b1;
                end
                WRITE: begin
                    src        <= src + one;
                    dst        <= dst + one;
                    len        <= len - one;
                    m_write_en <= 1'b0;
                    if (len != one) begin
                        state  <= READ;
                        m_addr <= src + one;
                    end else begin
                        state       <= FINISH;
                        bus_request <= 1'b0;
                        m_addr      <= '0;
                        done        <= 1'b1;
                        irq         <= 1'b1;
                    end
                end
                FINISH: begin
                    irq   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The responder's registered read data for the READ address arrives
    // during WRITE, so it is forwarded straight onto the write data bus.
    assign m_data_out = (state == WRITE) ? m_data_in : '0;

    always_comb begin
        ctrl_val      = '0;
        ctrl_val[1:0] = {done, busy};
    end

    always_comb begin
        data_out = '0;
        if (enable && !write_en) begin
            case (addr)
                2'd0:    data_out = src;
                2'd1:    data_out = dst;
                2'd2:    data_out = len;
                default: data_out = ctrl_val;
            endcase
        end
    end

endmodule

// File: tb/tb_reflet_dma.sv
// tb_reflet_dma: randomized self-checking bench for reflet_dma with a
// synchronous-read responder RAM and a byte-by-byte copy reference model.

module tb_reflet_dma;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] addr = 2'd0;
    logic       write_en = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       bus_request;
    logic [7:0] m_addr;
    logic       m_write_en;
    logic [7:0] m_data_out;
    logic [7:0] m_data_in;
    logic       irq;

    reflet_dma #(.wordsize(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .addr       (addr),
        .write_en   (write_en),
        .data_in    (data_in),
        .data_out   (data_out),
        .bus_request(bus_request),
        .m_addr     (m_addr),
        .m_write_en (m_write_en),
        .m_data_out (m_data_out),
        .m_data_in  (m_data_in),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // responder RAM with registered read data and a bench preload port
    logic [7:0] ram [256];
    logic [7:0] rdata = 8'h00;
    logic       ld_en = 1'b0;
    logic [7:0] ld_addr = 8'h00;
    logic [7:0] ld_data = 8'h00;

    always @(posedge clk) begin
        if (ld_en) ram[ld_addr] <= ld_data;
        else if (m_write_en) ram[m_addr] <= m_data_out;
        rdata <= ram[m_addr];
    end
    assign m_data_in = rdata;

    // bus activity monitor
    int         breq_cnt = 0;
    int         irq_cnt = 0;
    logic [7:0] waddr_q[$];

    always @(posedge clk) begin
        if (bus_request) breq_cnt++;
        if (irq) irq_cnt++;
        if (m_write_en) waddr_q.push_back(m_addr);
    end

    int vectors = 0;
    int errors = 0;

    logic [7:0] img  [256];
    logic [7:0] expm [256];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
        enable = 1'b1; write_en = 1'b1; addr = a; data_in = d;
        @(posedge clk); #1;
        enable = 1'b0; write_en = 1'b0; data_in = 8'h00;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [7:0] d);
        enable = 1'b1; write_en = 1'b0; addr = a;
        #1;
        d = data_out;
        enable = 1'b0;
    endtask

    task automatic load_ram();
        for (int i = 0; i < 256; i++) begin
            img[i]  = 8'($urandom);
            ld_en   = 1'b1;
            ld_addr = 8'(i);
            ld_data = img[i];
            @(posedge clk); #1;
        end
        ld_en = 1'b0;
    endtask

    task automatic clear_mon();
        breq_cnt = 0;
        irq_cnt  = 0;
        waddr_q.delete();
    endtask

    task automatic program_regs(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
        reg_write(2'd0, s);
        reg_write(2'd1, d);
        reg_write(2'd2, l);
    endtask

    // Full copy: preload, run, and compare against the sequential model.
    task automatic run_copy(input string tag, input logic [7:0] s, input logic [7:0] d,
                            input logic [7:0] l, input bit poke, input bit preset);
        logic [7:0] v;
        logic [7:0] a;
        int bad;
        if (!preset) load_ram();
        for (int i = 0; i < 256; i++) expm[i] = img[i];
        for (int i = 0; i < int'(l); i++) expm[8'(d + 8'(i))] = expm[8'(s + 8'(i))];
        program_regs(s, d, l);
        clear_mon();
        reg_write(2'd3, 8'h01);
        if (poke) begin
            // register writes while busy must have no effect
            reg_write(2'd2, 8'h55);
            reg_write(2'd0, 8'h00);
            reg_write(2'd3, 8'h02);
        end
        for (int c = 0; c < 2 * int'(l) + 20 && irq_cnt == 0; c++) @(posedge clk);
        #1;
        check({tag, " irq_seen"}, 32'(irq_cnt != 0), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check({tag, " irq_count"}, 32'(irq_cnt), 32'd1);
        check({tag, " breq_cycles"}, 32'(breq_cnt), (l == 8'd0) ? 32'd0 : 32'(2 * int'(l) + 1));
        check({tag, " write_count"}, 32'(waddr_q.size()), 32'(l));
        bad = 0;
        for (int i = 0; i < waddr_q.size() && i < int'(l); i++) begin
            a = 8'(d + 8'(i));
            if (waddr_q[i] !== a) bad++;
        end
        check({tag, " write_addrs"}, 32'(bad), 32'd0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== expm[i]) bad++;
        check({tag, " ram_diffs"}, 32'(bad), 32'd0);
        reg_read(2'd0, v); check({tag, " src"},  32'(v), 32'(8'(s + l)));
        reg_read(2'd1, v); check({tag, " dst"},  32'(v), 32'(8'(d + l)));
        reg_read(2'd2, v); check({tag, " len"},  32'(v), 32'd0);
        reg_read(2'd3, v); check({tag, " ctrl"}, 32'(v), 32'h02);
        check({tag, " idle_bus"}, {29'd0, bus_request, m_write_en, irq}, 32'd0);
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] s;
        logic [7:0] d;
        logic [7:0] l;
        bit         poke;
        int         bad;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst outputs", {bus_request, m_addr, m_write_en, m_data_out, irq}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            reg_read(2'(i), v);
            check("rst regread", 32'(v), 32'd0);
        end
        reset = 1'b0;
        @(posedge clk); #1;

        // directed three-byte copy
        load_ram();
        img[8'h10] = 8'h11; img[8'h11] = 8'h22; img[8'h12] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            ld_en = 1'b1; ld_addr = 8'(8'h10 + i); ld_data = img[8'h10 + i];
            @(posedge clk); #1;
        end
        ld_en = 1'b0;
        run_copy("v1", 8'h10, 8'h40, 8'd3, 1'b0, 1'b1);
        check("v1 byte0", 32'(ram[8'h40]), 32'h11);
        check("v1 byte2", 32'(ram[8'h42]), 32'h33);

        // clearing done, and data_out gating
        reg_write(2'd3, 8'h02);
        reg_read(2'd3, v);
        check("v5 ctrl_cleared", 32'(v), 32'd0);
        enable = 1'b0; write_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            addr = 2'(i);
            #1;
            check("v5 gated_out", 32'(data_out), 32'd0);
        end

        // zero-length start
        run_copy("v2", 8'h05, 8'h90, 8'd0, 1'b0, 1'b0);

        // address wrap
        run_copy("v3", 8'hFE, 8'h80, 8'd3, 1'b0, 1'b0);

        // randomized copies, some with register pokes while busy
        for (int n = 0; n < 10; n++) begin
            poke = n[0];
            s = 8'($urandom);
            d = 8'($urandom);
            l = poke ? 8'($urandom_range(4, 16)) : 8'($urandom_range(1, 16));
            run_copy("rand", s, d, l, poke, 1'b0);
        end

        // reset during the second byte of a four-byte copy
        load_ram();
        program_regs(8'h20, 8'h60, 8'd4);
        clear_mon();
        reg_write(2'd3, 8'h01);
        bad = 1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (waddr_q.size() >= 1) begin
                bad = 0;
                break;
            end
        end
        check("v4 first_write_seen", 32'(bad), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("v4 outputs_now", {bus_request, m_addr, m_write_en, m_data_out, irq}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            reg_read(2'(i), v);
            check("v4 regread", 32'(v), 32'd0);
        end
        repeat (12) @(posedge clk);
        #1;
        check("v4 no_irq", 32'(irq_cnt), 32'd0);
        check("v4 writes_le2", 32'(waddr_q.size() <= 2), 32'd1);
        check("v4 bus_idle", {31'd0, bus_request}, 32'd0);
        check("v4 byte0", 32'(ram[8'h60]), 32'(img[8'h20]));
        check("v4 byte2_untouched", 32'(ram[8'h62]), 32'(img[8'h62]));
        check("v4 byte3_untouched", 32'(ram[8'h63]), 32'(img[8'h63]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
